// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction fetch with one outstanding imem request and a one-entry decode register.
// Latency: instr_valid rises the cycle after the request cycle that saw imem_ack; S_BOOT adds one idle cycle after reset.
// Backpressure: instr_ready=0 or stall=1 holds instr/instr_pc and blocks the next request; branches and memory traffic ignore stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_BIAS  = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] target_sum;
  logic [31:0] branch_target;
  logic [31:0] fetch_pc;
  logic        in_req;
  logic        in_hold;
  logic        fetch_done;
  logic        handshake;
  logic        enter_req;

  // The shift stage already word-aligns the offset; the low bits are cleared
  // anyway so a misaligned branch_pc can never produce a misaligned fetch.
  assign target_sum    = branch_pc + PC_BIAS + branch_offset;
  assign branch_target = {target_sum[31:2], 2'b00};

  assign in_req  = (state == S_REQ);
  assign in_hold = (state == S_HOLD);

  // An ack that coincides with a branch belongs to the flushed path.
  assign fetch_done = in_req && imem_ack && !branch_taken;

  // Decode takes the word only when not stalled and not being flushed.
  assign handshake = in_hold && instr_ready && !stall && !branch_taken;

  // Address for a request that starts next cycle; a branch this cycle wins.
  assign fetch_pc = branch_taken ? branch_target : pc;

  // A new request begins when entering S_REQ from another state, or when a
  // branch lands on the ack cycle and S_REQ restarts at the target.
  assign enter_req = (state_nxt == S_REQ) && (!in_req || imem_ack);

  // State register; reset parks the FSM in S_BOOT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a taken branch outranks both ack and the decode handshake
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (branch_taken) begin
          // An unacked request cannot be withdrawn, so wait it out in S_DROP.
          state_nxt = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          state_nxt = S_HOLD;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (branch_taken || handshake) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // Moore output: the memory request stays up until its ack, even when the data will be dropped
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      S_REQ, S_DROP: imem_req = 1'b1;
      default:       imem_req = 1'b0;
    endcase
  end

  // Program counter: branch target has priority over the post-fetch increment
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (fetch_done) begin
      pc <= pc + 32'd4;
    end
  end

  // Request address is captured once at request start and held until the ack
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr <= 32'd0;
    end else if (enter_req) begin
      imem_addr <= fetch_pc;
    end
  end

  // Decode register: load on a clean ack, clear on handshake or flush, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
    end else begin
      if (fetch_done) begin
        instr    <= imem_rdata;
        instr_pc <= imem_addr;
      end
      if (branch_taken) begin
        instr_valid <= 1'b0;
      end else if (fetch_done) begin
        instr_valid <= 1'b1;
      end else if (handshake) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by randomized traffic for pc_fetch_unit.
// A second instance with a wrapping reset PC runs in lockstep on the same inputs.
// Expected behaviour comes from a transaction-level model of PC flow, request tainting and flushes.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  // stimulus controls
  logic        drv_reset, drv_stall, drv_ready, drv_branch;
  logic [31:0] drv_bpc, drv_boff;
  int          ack_delay;
  int          wcnt;
  bit          rand_ack;

  // reference model state
  bit          m_known, m_boot, m_pv, m_ract, m_taint;
  logic [31:0] m_pc, m_paddr, m_raddr;
  int          n_accept;

  int          n_chk;
  int          n_pass;

  pc_fetch_unit #(.RESET_PC(RST_PC), .PC_BIAS(32'd8)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  pc_fetch_unit #(.RESET_PC(WRAP_PC), .PC_BIAS(32'd8)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // memory contents as a pure function of address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] bpc, input logic [31:0] off);
    logic [31:0] s;
    s = bpc + 32'd8 + off;
    return {s[31:2], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // compare current outputs with the model's expectation for this cycle
  task automatic model_check();
    if (!m_known) return;
    if (m_boot) begin
      chkb("m_boot_req", imem_req, 1'b0);
      chk("m_boot_addr", imem_addr, 32'd0);
      chkb("m_boot_valid", instr_valid, 1'b0);
      chk("m_boot_instr", instr, 32'd0);
      chk("m_boot_ipc", instr_pc, 32'd0);
    end else begin
      chkb("m_busy", imem_req | instr_valid, 1'b1);
    end
    chkb("m_valid", instr_valid, m_pv);
    if (m_pv) begin
      chk("m_ipc", instr_pc, m_paddr);
      chk("m_instr", instr, word_at(m_paddr));
    end
    chkb("m_req_and_valid", imem_req & instr_valid, 1'b0);
    if (imem_req) begin
      if (!m_ract) chk("m_req_addr", imem_addr, m_pc);
      else         chk("m_addr_stable", imem_addr, m_raddr);
    end
  endtask

  // advance the model with the inputs the coming clock edge will see
  task automatic model_update();
    bit pv_now;
    if (reset) begin
      m_known = 1; m_boot = 1; m_pc = RST_PC; m_pv = 0; m_ract = 0; m_taint = 0;
      return;
    end
    if (!m_known) return;
    m_boot = 0;
    pv_now = m_pv;
    if (pv_now && instr_ready && !stall && !branch_taken) begin
      m_pv = 0;
      n_accept = n_accept + 1;
    end
    if (imem_req) begin
      if (!m_ract) begin
        m_ract = 1; m_raddr = imem_addr; m_taint = 0;
      end
      if (branch_taken) m_taint = 1;
      if (imem_ack) begin
        m_ract = 0;
        if (!m_taint) begin
          m_pv = 1; m_paddr = m_raddr; m_pc = m_raddr + 32'd4;
        end
      end
    end
    if (branch_taken) begin
      m_pv = 0;
      m_pc = tgt_of(branch_pc, branch_offset);
    end
  endtask

  // one clock cycle: drive inputs, run the memory responder and model, advance past the edge
  task automatic cyc();
    reset         = drv_reset;
    stall         = drv_stall;
    instr_ready   = drv_ready;
    branch_taken  = drv_branch;
    branch_pc     = drv_bpc;
    branch_offset = drv_boff;
    if (imem_req) begin
      if (rand_ack) imem_ack = ($urandom_range(0, 2) == 0);
      else          imem_ack = (wcnt >= ack_delay);
      wcnt = imem_ack ? 0 : wcnt + 1;
    end else begin
      imem_ack = 1'b0;
      wcnt = 0;
    end
    imem_rdata = word_at(imem_addr);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_accept = 0;
    m_known = 0; m_boot = 0; m_pv = 0; m_ract = 0; m_taint = 0;
    m_pc = '0; m_paddr = '0; m_raddr = '0;
    wcnt = 0; ack_delay = 0; rand_ack = 0;
    drv_reset = 1; drv_stall = 0; drv_ready = 1; drv_branch = 0; drv_bpc = '0; drv_boff = '0;
    reset = 1; stall = 0; instr_ready = 1; branch_taken = 0; branch_pc = '0; branch_offset = '0;
    imem_ack = 0; imem_rdata = '0;
    @(posedge clk); #1;
    cyc();
    cyc();
    drv_reset = 0;

    // idle boot cycle with reset values
    chkb("boot_req", imem_req, 1'b0);
    chk("boot_addr", imem_addr, 32'd0);
    chkb("boot_valid", instr_valid, 1'b0);
    chk("boot_instr", instr, 32'd0);
    chk("boot_ipc", instr_pc, 32'd0);
    chk("boot_w_addr", w_imem_addr, 32'd0);

    // sequential fetch, ack in the request cycle, decode always ready
    cyc();
    chkb("a_req0", imem_req, 1'b1);
    chk("a_addr0", imem_addr, 32'd0);
    chkb("a_w_req0", w_imem_req, 1'b1);
    chk("a_w_addr0", w_imem_addr, WRAP_PC);
    chkb("a_valid_early", instr_valid, 1'b0);
    cyc();
    chkb("a_valid0", instr_valid, 1'b1);
    chk("a_ipc0", instr_pc, 32'd0);
    chk("a_instr0", instr, word_at(32'd0));
    chkb("a_w_valid0", w_instr_valid, 1'b1);
    chk("a_w_ipc0", w_instr_pc, WRAP_PC);
    cyc();
    chk("a_addr1", imem_addr, 32'd4);
    chk("a_w_addr1", w_imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("a_ipc1", instr_pc, 32'd4);
    chk("a_w_ipc1", w_instr_pc, 32'hFFFF_FFFC);
    cyc();
    chk("a_addr2", imem_addr, 32'd8);
    chk("a_w_addr2", w_imem_addr, 32'd0);
    cyc();
    chk("a_ipc2", instr_pc, 32'd8);
    chk("a_w_ipc2", w_instr_pc, 32'd0);
    chk("a_w_instr2", w_instr, word_at(32'd8));

    // backpressure: five cycles not ready, then two cycles stalled
    drv_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chkb("bp_valid", instr_valid, 1'b1);
      chk("bp_ipc", instr_pc, 32'd8);
      chk("bp_instr", instr, word_at(32'd8));
      chkb("bp_noreq", imem_req, 1'b0);
    end
    drv_ready = 1; drv_stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chkb("st_valid", instr_valid, 1'b1);
      chk("st_ipc", instr_pc, 32'd8);
      chkb("st_noreq", imem_req, 1'b0);
    end
    drv_stall = 0;
    cyc();
    chkb("hs_valid_clear", instr_valid, 1'b0);
    chkb("hs_req", imem_req, 1'b1);
    chk("hs_addr", imem_addr, 32'd12);

    // branch while holding, positive then negative offset
    cyc();
    chk("c_ipc", instr_pc, 32'd12);
    drv_ready = 0; drv_branch = 1; drv_bpc = 32'h100; drv_boff = 32'h40;
    cyc();
    drv_branch = 0;
    chkb("c_flush", instr_valid, 1'b0);
    chkb("c_req", imem_req, 1'b1);
    chk("c_target", imem_addr, 32'h148);
    cyc();
    chk("c_ipc_tgt", instr_pc, 32'h148);
    drv_branch = 1; drv_bpc = 32'h100; drv_boff = 32'hFFFF_FFF0;
    cyc();
    drv_branch = 0;
    chkb("c_flush_neg", instr_valid, 1'b0);
    chk("c_target_neg", imem_addr, 32'hF8);

    // branch while a slow request is outstanding, then a second branch in S_DROP
    ack_delay = 3;
    drv_branch = 1; drv_bpc = 32'h200; drv_boff = 32'h20;
    cyc();
    drv_bpc = 32'h400; drv_boff = 32'hFFFF_FFF8;
    chkb("d_req_held", imem_req, 1'b1);
    chk("d_addr_held1", imem_addr, 32'hF8);
    cyc();
    drv_branch = 0;
    chk("d_addr_held2", imem_addr, 32'hF8);
    chkb("d_novalid", instr_valid, 1'b0);
    cyc();
    chk("d_addr_held3", imem_addr, 32'hF8);
    cyc();
    chkb("d_dropped", instr_valid, 1'b0);
    chk("d_new_target", imem_addr, 32'h400);
    ack_delay = 0;
    cyc();
    chk("d_ipc", instr_pc, 32'h400);
    chk("d_instr", instr, word_at(32'h400));

    // branch on the same cycle as the ack
    drv_ready = 1;
    cyc();
    chk("e_addr", imem_addr, 32'h404);
    drv_branch = 1; drv_bpc = 32'h300; drv_boff = 32'h0;
    cyc();
    drv_branch = 0;
    chkb("e_valid", instr_valid, 1'b0);
    chk("e_target", imem_addr, 32'h308);

    // reset while requesting
    drv_reset = 1;
    cyc();
    drv_reset = 0;
    chkb("r1_req", imem_req, 1'b0);
    chk("r1_addr", imem_addr, 32'd0);
    chkb("r1_valid", instr_valid, 1'b0);
    chk("r1_instr", instr, 32'd0);
    cyc();
    chkb("r1_req_after", imem_req, 1'b1);
    chk("r1_addr_after", imem_addr, RST_PC);

    // reset while holding
    cyc();
    chkb("r2_hold", instr_valid, 1'b1);
    drv_ready = 0; drv_reset = 1;
    cyc();
    drv_reset = 0;
    chkb("r2_valid", instr_valid, 1'b0);
    chk("r2_ipc", instr_pc, 32'd0);
    chkb("r2_req", imem_req, 1'b0);
    cyc();
    chkb("r2_req_after", imem_req, 1'b1);
    chk("r2_addr_after", imem_addr, RST_PC);
    chk("r2_w_addr_after", w_imem_addr, WRAP_PC);

    // randomized traffic against the model
    rand_ack = 1;
    for (int i = 0; i < 3000; i++) begin
      drv_reset  = ($urandom_range(0, 299) == 0);
      drv_ready  = ($urandom_range(0, 3) != 0);
      drv_stall  = ($urandom_range(0, 3) == 0);
      drv_branch = ($urandom_range(0, 11) == 0);
      drv_bpc    = $urandom();
      if ($urandom_range(0, 1) == 1) drv_boff = $urandom();
      else drv_boff = 32'((int'($urandom_range(0, 511)) - 256) * 4);
      cyc();
    end
    drv_reset = 0; drv_branch = 0;

    chkb("progress", (n_accept >= 200), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
